// File: rtl/io_pkg.sv
// Shared constants and address decode for the memory-mapped I/O buffer bank.
package io_pkg;

  localparam logic [15:0] IO_OUT_BASE = 16'h1000;
  localparam logic [15:0] IO_IN_BASE  = 16'h1001;

  localparam logic [3:0] SEL_LEDR = 4'h0;
  localparam logic [3:0] SEL_LEDG = 4'h1;
  localparam logic [3:0] SEL_HEXL = 4'h2;
  localparam logic [3:0] SEL_HEXH = 4'h3;
  localparam logic [3:0] SEL_LCD  = 4'h4;

  // Active-low segments: every segment dark
  localparam logic [31:0] HEX_BLANK = 32'h7F7F_7F7F;

  typedef enum logic [2:0] {
    DEV_LEDR,
    DEV_LEDG,
    DEV_HEXL,
    DEV_HEXH,
    DEV_LCD,
    DEV_NONE
  } io_dev_e;

  // The switch region (IO_IN_BASE) is read-only, so it decodes to DEV_NONE like any unmapped page
  function automatic io_dev_e io_decode(input logic [31:0] addr);
    io_dev_e dev;
    dev = DEV_NONE;
    if (addr[31:16] == IO_OUT_BASE) begin
      case (addr[15:12])
        SEL_LEDR: dev = DEV_LEDR;
        SEL_LEDG: dev = DEV_LEDG;
        SEL_HEXL: dev = DEV_HEXL;
        SEL_HEXH: dev = DEV_HEXH;
        SEL_LCD:  dev = DEV_LCD;
        default:  dev = DEV_NONE;
      endcase
    end
    return dev;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: invert, 2-flop synchronise, then require DB_LIMIT steady cycles before accepting a new level.
module btn_debounce #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic stable
);

  logic                sync_p0;
  logic                sync_p1;
  logic [DB_CNT_W-1:0] cnt;

  // Synchroniser stage: raw is active-low, so the flops hold "pressed"
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ~btn_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt == DB_CNT_W'(DB_LIMIT - 1)) begin
      cnt    <= '0;
      stable <= sync_p1;
    end else begin
      cnt <= cnt + DB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_buffer.sv
// Memory-mapped output buffers with byte-lane stores, plus switch synchroniser and button debouncers.
module io_buffer
  import io_pkg::*;
#(
  parameter int DB_LIMIT = 50000,
  parameter int DB_CNT_W = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_en,
  input  logic        f_io_valid,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_st_strb,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] b_io_ledr,
  output logic [31:0] b_io_ledg,
  output logic [31:0] b_io_hexl,
  output logic [31:0] b_io_hexh,
  output logic [31:0] b_io_lcd,
  output logic [31:0] b_io_sw,
  output logic [31:0] b_io_btn,
  output logic        o_st_err
);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  io_dev_e     dev;
  logic        st_acc;
  logic        st_wr;
  logic [31:0] sw_p0;
  logic [3:0]  btn_stable;

  assign dev    = io_decode(i_st_addr);
  assign st_acc = i_st_en && f_io_valid;
  // An all-zero strobe is a no-op everywhere, including unmapped pages
  assign st_wr  = st_acc && (i_st_strb != 4'b0000);

  // Store stage: data in cycle N is visible from N+1; reset outranks a coincident store
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      b_io_ledr <= '0;
      b_io_ledg <= '0;
      b_io_hexl <= HEX_BLANK;
      b_io_hexh <= HEX_BLANK;
      b_io_lcd  <= '0;
      o_st_err  <= 1'b0;
    end else begin
      o_st_err <= st_wr && (dev == DEV_NONE);
      if (st_wr) begin
        case (dev)
          DEV_LEDR: b_io_ledr <= byte_merge(b_io_ledr, i_st_data, i_st_strb);
          DEV_LEDG: b_io_ledg <= byte_merge(b_io_ledg, i_st_data, i_st_strb);
          DEV_HEXL: b_io_hexl <= byte_merge(b_io_hexl, i_st_data, i_st_strb);
          DEV_HEXH: b_io_hexh <= byte_merge(b_io_hexh, i_st_data, i_st_strb);
          DEV_LCD:  b_io_lcd  <= byte_merge(b_io_lcd,  i_st_data, i_st_strb);
          default:  ;
        endcase
      end
    end
  end

  // Switch synchroniser stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_p0   <= '0;
      b_io_sw <= '0;
    end else begin
      sw_p0   <= i_io_sw;
      b_io_sw <= sw_p0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DB_LIMIT (DB_LIMIT),
      .DB_CNT_W (DB_CNT_W)
    ) u_btn_debounce (
      .clk    (i_clk),
      .rst    (i_reset),
      .btn_n  (i_io_btn[g]),
      .stable (btn_stable[g])
    );
  end

  assign b_io_btn = {28'b0, btn_stable};

endmodule

// File: tb/tb_io_buffer.sv
// Directed bench for io_buffer with a short debounce window.
module tb_io_buffer;

  localparam int DB_LIMIT = 8;
  localparam int DB_CNT_W = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_st_en;
  logic        f_io_valid;
  logic [31:0] i_st_addr;
  logic [31:0] i_st_data;
  logic [3:0]  i_st_strb;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [31:0] b_io_ledr;
  logic [31:0] b_io_ledg;
  logic [31:0] b_io_hexl;
  logic [31:0] b_io_hexh;
  logic [31:0] b_io_lcd;
  logic [31:0] b_io_sw;
  logic [31:0] b_io_btn;
  logic        o_st_err;

  int compared   = 0;
  int mismatched = 0;

  io_buffer #(
    .DB_LIMIT (DB_LIMIT),
    .DB_CNT_W (DB_CNT_W)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_st_en    (i_st_en),
    .f_io_valid (f_io_valid),
    .i_st_addr  (i_st_addr),
    .i_st_data  (i_st_data),
    .i_st_strb  (i_st_strb),
    .i_io_sw    (i_io_sw),
    .i_io_btn   (i_io_btn),
    .b_io_ledr  (b_io_ledr),
    .b_io_ledg  (b_io_ledg),
    .b_io_hexl  (b_io_hexl),
    .b_io_hexh  (b_io_hexh),
    .b_io_lcd   (b_io_lcd),
    .b_io_sw    (b_io_sw),
    .b_io_btn   (b_io_btn),
    .o_st_err   (o_st_err)
  );

  always #5 i_clk = ~i_clk;

  // Advance one active edge, then settle so outputs are read away from the edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic valid);
    i_st_en    = 1'b1;
    f_io_valid = valid;
    i_st_addr  = addr;
    i_st_data  = data;
    i_st_strb  = strb;
    step();
    i_st_en    = 1'b0;
    f_io_valid = 1'b0;
  endtask

  task automatic chk_bufs(input string tag, input logic [31:0] ledr, input logic [31:0] ledg,
                          input logic [31:0] hexl, input logic [31:0] hexh, input logic [31:0] lcd);
    chk({tag, "_ledr"}, b_io_ledr, ledr);
    chk({tag, "_ledg"}, b_io_ledg, ledg);
    chk({tag, "_hexl"}, b_io_hexl, hexl);
    chk({tag, "_hexh"}, b_io_hexh, hexh);
    chk({tag, "_lcd"},  b_io_lcd,  lcd);
  endtask

  initial begin
    i_reset    = 1'b1;
    i_st_en    = 1'b0;
    f_io_valid = 1'b0;
    i_st_addr  = '0;
    i_st_data  = '0;
    i_st_strb  = '0;
    i_io_sw    = '0;
    i_io_btn   = 4'hF;

    // Reset values
    step();
    step();
    chk_bufs("rst", 32'h0, 32'h0, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h0);
    chk("rst_sw",  b_io_sw,  32'h0);
    chk("rst_btn", b_io_btn, 32'h0);
    chk("rst_err", {31'b0, o_st_err}, 32'h0);
    i_reset = 1'b0;
    step();

    // Byte-lane stores
    store(32'h1000_0000, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    chk("ledr_word", b_io_ledr, 32'hDEAD_BEEF);
    chk("ledr_word_err", {31'b0, o_st_err}, 32'h0);
    store(32'h1000_0000, 32'h0000_5500, 4'b0010, 1'b1);
    chk("ledr_lane1", b_io_ledr, 32'hDEAD_55EF);
    store(32'h1000_1ABC, 32'h1234_5678, 4'b1111, 1'b1);
    chk("ledg_lowbits_ignored", b_io_ledg, 32'h1234_5678);
    store(32'h1000_2000, 32'h0000_00C0, 4'b0001, 1'b1);
    chk("hexl_bit7", b_io_hexl, 32'h7F7F_7FC0);
    store(32'h1000_3000, 32'hAA00_0000, 4'b1000, 1'b1);
    chk("hexh_lane3", b_io_hexh, 32'hAA7F_7F7F);
    store(32'h1000_4000, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    chk("lcd_nostrb", b_io_lcd, 32'h0);
    chk("lcd_nostrb_err", {31'b0, o_st_err}, 32'h0);
    store(32'h1000_4000, 32'h0000_0041, 4'b0001, 1'b1);
    chk("lcd_lane0", b_io_lcd, 32'h0000_0041);

    // Error paths
    store(32'h1001_0000, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    chk("err_sw_pulse", {31'b0, o_st_err}, 32'h1);
    chk("err_sw_swbuf", b_io_sw, 32'h0);
    chk_bufs("err_sw", 32'hDEAD_55EF, 32'h1234_5678, 32'h7F7F_7FC0, 32'hAA7F_7F7F, 32'h41);
    step();
    chk("err_sw_onecycle", {31'b0, o_st_err}, 32'h0);
    store(32'h1000_7000, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    chk("err_7000_pulse", {31'b0, o_st_err}, 32'h1);
    chk_bufs("err_7000", 32'hDEAD_55EF, 32'h1234_5678, 32'h7F7F_7FC0, 32'hAA7F_7F7F, 32'h41);
    step();
    chk("err_7000_onecycle", {31'b0, o_st_err}, 32'h0);
    store(32'h2000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    chk("err_upper_pulse", {31'b0, o_st_err}, 32'h1);
    store(32'h1000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    chk("novalid_err", {31'b0, o_st_err}, 32'h0);
    chk("novalid_ledr", b_io_ledr, 32'hDEAD_55EF);

    // Back-to-back stores to one register
    store(32'h1000_1000, 32'h1111_1111, 4'b1111, 1'b1);
    chk("b2b_first", b_io_ledg, 32'h1111_1111);
    store(32'h1000_1000, 32'h2222_2222, 4'b1111, 1'b1);
    chk("b2b_second", b_io_ledg, 32'h2222_2222);

    // Switch synchroniser: two edges
    i_io_sw = 32'h0000_03FF;
    step();
    chk("sw_edge1", b_io_sw, 32'h0);
    step();
    chk("sw_edge2", b_io_sw, 32'h0000_03FF);

    // Debounce: 5-cycle glitch is rejected
    i_io_btn = 4'hE;
    for (int i = 0; i < 5; i++) step();
    i_io_btn = 4'hF;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("glitch_btn", b_io_btn, 32'h0);
    end

    // Debounce: steady press rises DB_LIMIT+2 edges after the raw fall
    i_io_btn = 4'hE;
    for (int i = 0; i < 9; i++) step();
    chk("press_edge9", b_io_btn, 32'h0);
    step();
    chk("press_edge10", b_io_btn, 32'h1);
    for (int i = 0; i < 10; i++) step();
    chk("press_held", b_io_btn, 32'h1);
    i_io_btn = 4'hF;
    for (int i = 0; i < 9; i++) step();
    chk("release_edge9", b_io_btn, 32'h1);
    step();
    chk("release_edge10", b_io_btn, 32'h0);

    // Reset in the middle of a count
    i_io_btn = 4'hE;
    for (int i = 0; i < 5; i++) step();
    i_io_btn = 4'hF;
    i_reset  = 1'b1;
    step();
    i_reset  = 1'b0;
    chk("midrst_btn", b_io_btn, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("midrst_btn_after", b_io_btn, 32'h0);

    // Reset beats a simultaneous store
    i_reset = 1'b1;
    store(32'h1000_2000, 32'h1234_5678, 4'b1111, 1'b1);
    i_reset = 1'b0;
    chk("rstprio_hexl", b_io_hexl, 32'h7F7F_7F7F);
    chk("rstprio_err", {31'b0, o_st_err}, 32'h0);
    chk("rstprio_ledr", b_io_ledr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
